// File: rtl/event_qualifier_if.sv
// Sample-in / record-out bundle for the event qualifier.
// master drives samples and accepts records; slave is the qualifier.
interface event_qualifier_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) ();
  logic                    in_valid;
  logic                    in_flag;
  logic signed [WIDTH-1:0] in_sample;
  logic                    rec_valid;
  logic                    rec_ready;
  logic signed [WIDTH-1:0] rec_peak;
  logic [LEN_W-1:0]        rec_len;
  logic [CNT_W-1:0]        rec_index;

  modport master (
    output in_valid, in_flag, in_sample, rec_ready,
    input  rec_valid, rec_peak, rec_len, rec_index
  );

  modport slave (
    input  in_valid, in_flag, in_sample, rec_ready,
    output rec_valid, rec_peak, rec_len, rec_index
  );
endinterface

// File: rtl/event_qualifier.sv
// Debounces detector flags into qualified events with hold-off and
// emits one peak/length/index record per event over valid/ready.
module event_qualifier #(
  parameter int WIDTH     = 16,
  parameter int ON_COUNT  = 3,
  parameter int OFF_COUNT = 3,
  parameter int HOLDOFF   = 8,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  event_qualifier_if.slave bus,
  input  logic             clr_ovf,
  output logic             event_start,
  output logic             event_active,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_ACT,
    S_REL,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           run_q, run_d;
  logic [CW-1:0]           off_q, off_d;
  logic [CW-1:0]           hold_q, hold_d;
  logic [LEN_W-1:0]        span_q, span_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    start_q, start_d;
  logic                    act_q, act_d;
  logic                    ovf_q, ovf_d;
  logic                    rv_q, rv_d;
  logic signed [WIDTH-1:0] rp_q, rp_d;
  logic [LEN_W-1:0]        rl_q, rl_d;
  logic [CNT_W-1:0]        ri_q, ri_d;

  logic                    confirm;
  logic                    fin;
  logic [LEN_W-1:0]        span_inc;
  logic signed [WIDTH-1:0] peak_max;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    off_d    = off_q;
    hold_d   = hold_q;
    span_d   = span_q;
    len_d    = len_q;
    peak_d   = peak_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    ovf_d    = ovf_q;
    rv_d     = rv_q;
    rp_d     = rp_q;
    rl_d     = rl_q;
    ri_d     = ri_q;
    confirm  = 1'b0;
    fin      = 1'b0;
    span_inc = (&span_q) ? span_q : span_q + 1'b1;
    peak_max = (bus.in_sample > peak_q) ? bus.in_sample : peak_q;

    if (rv_q && bus.rec_ready) rv_d = 1'b0;
    if (clr_ovf) ovf_d = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_flag) begin
            run_d  = CW'(1);
            span_d = LEN_W'(1);
            len_d  = LEN_W'(1);
            peak_d = bus.in_sample;
            if (ON_COUNT == 1) confirm = 1'b1;
            else state_d = S_PEND;
          end
        end
        S_PEND: begin
          if (bus.in_flag) begin
            run_d  = run_q + 1'b1;
            span_d = span_inc;
            len_d  = span_inc;
            peak_d = peak_max;
            if (run_d == CW'(ON_COUNT)) confirm = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACT: begin
          span_d = span_inc;
          peak_d = peak_max;
          if (bus.in_flag) begin
            len_d = span_inc;
          end else begin
            off_d = CW'(1);
            if (OFF_COUNT == 1) fin = 1'b1;
            else state_d = S_REL;
          end
        end
        S_REL: begin
          span_d = span_inc;
          peak_d = peak_max;
          if (bus.in_flag) begin
            len_d   = span_inc;
            off_d   = '0;
            state_d = S_ACT;
          end else begin
            off_d = off_q + 1'b1;
            if (off_d == CW'(OFF_COUNT)) fin = 1'b1;
          end
        end
        S_HOLD: begin
          hold_d = hold_q + 1'b1;
          if (hold_d == CW'(HOLDOFF)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (confirm) begin
        state_d = S_ACT;
        start_d = 1'b1;
        off_d   = '0;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end

      // A busy record slot keeps the old record; the new one is lost.
      if (fin) begin
        if (!rv_q || bus.rec_ready) begin
          rv_d = 1'b1;
          rp_d = peak_d;
          rl_d = len_d;
          ri_d = cnt_q;
        end else begin
          ovf_d = 1'b1;
        end
        hold_d  = '0;
        state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
      end
    end

    act_d = (state_d == S_ACT) || (state_d == S_REL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      off_q   <= '0;
      hold_q  <= '0;
      span_q  <= '0;
      len_q   <= '0;
      peak_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      act_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
      rp_q    <= '0;
      rl_q    <= '0;
      ri_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
      span_q  <= span_d;
      len_q   <= len_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      act_q   <= act_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
      rp_q    <= rp_d;
      rl_q    <= rl_d;
      ri_q    <= ri_d;
    end
  end

  assign event_start   = start_q;
  assign event_active  = act_q;
  assign event_count   = cnt_q;
  assign overflow      = ovf_q;
  assign bus.rec_valid = rv_q;
  assign bus.rec_peak  = rp_q;
  assign bus.rec_len   = rl_q;
  assign bus.rec_index = ri_q;

endmodule
